montgomery_iter_core: RTL and testbench

Radix-2 bit-serial Montgomery iteration engine for the proposed Algorithm 4 datapath. Computes S = A*B*2^-k mod M, with S held in [0, 2M). Sits directly upstream of the (k+1)-bit 2:1 final-correction mux and drives its three inputs: i_A <- o_S, i_B <- o_D, i_Sel <- o_Sel. Mux output is the fully reduced product.

---
 rtl/montgomery_iter_core_if.sv | 14 +
 rtl/montgomery_iter_core.sv | 68 ++++++
 tb/tb_montgomery_iter_core.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/montgomery_iter_core_if.sv
// montgomery_iter_core_if: start/operand request and result bus of the Montgomery core
interface montgomery_iter_core_if #(parameter int K_BITS = 8);
    logic              i_start;
    logic [K_BITS-1:0] i_A;
    logic [K_BITS-1:0] i_B;
    logic [K_BITS-1:0] i_M;
    logic              o_busy;
    logic              o_done;
    logic [K_BITS:0]   o_S;
    logic [K_BITS:0]   o_D;
    logic              o_Sel;
    modport master (output i_start, i_A, i_B, i_M, input o_busy, o_done, o_S, o_D, o_Sel);
    modport slave  (input i_start, i_A, i_B, i_M, output o_busy, o_done, o_S, o_D, o_Sel);
endinterface

// File: rtl/montgomery_iter_core.sv
// montgomery_iter_core: radix-2 bit-serial Montgomery multiply, S = A*B*2^-k mod M with S in [0, 2M)
module montgomery_iter_core #(parameter int K_BITS = 8) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    montgomery_iter_core_if.slave bus
);
    localparam int CW = $clog2(K_BITS);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state;
    logic [K_BITS-1:0] a_r, b_r, m_r;
    logic [K_BITS:0]   acc, nxt;
    logic [CW-1:0]     cnt;
    logic [K_BITS+1:0] sum_ab, sum_q, diff;
    logic              last;
    always_comb begin
        sum_ab = {1'b0, acc} + (a_r[cnt] ? {2'b0, b_r} : '0);
        // the parity of S + a*B is exactly q, so adding q*M makes the sum even
        sum_q  = sum_ab + (sum_ab[0] ? {2'b0, m_r} : '0);
        nxt    = sum_q[K_BITS+1:1];
        diff   = {1'b0, nxt} - {2'b0, m_r};
        last   = cnt == CW'(K_BITS - 1);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            m_r        <= '0;
            acc        <= '0;
            cnt        <= '0;
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b0;
            bus.o_S    <= '0;
            bus.o_D    <= '0;
            bus.o_Sel  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.i_start) begin
                    a_r        <= bus.i_A;
                    b_r        <= bus.i_B;
                    m_r        <= bus.i_M;
                    acc        <= '0;
                    cnt        <= '0;
                    bus.o_busy <= 1'b1;
                    state      <= RUN;
                end
                RUN: begin
                    acc <= nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        // the top bit of the k+2-bit difference is the borrow of S - M
                        bus.o_S    <= nxt;
                        bus.o_D    <= diff[K_BITS:0];
                        bus.o_Sel  <= ~diff[K_BITS+1];
                        bus.o_busy <= 1'b0;
                        bus.o_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    bus.o_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_montgomery_iter_core.sv
// tb_montgomery_iter_core: scoreboard bench comparing the core against a modular-arithmetic reference
module tb_montgomery_iter_core;
    localparam int K = 8;
    localparam int MASK = (1 << (K + 1)) - 1;
    typedef struct {int sel; int m; bit exact; int s; int d;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_done = -1;
    bit   gap_en = 1'b0;
    exp_t sb[$];
    exp_t e;
    int   ms, md, msel;
    montgomery_iter_core_if #(.K_BITS(K)) bus();
    montgomery_iter_core #(.K_BITS(K)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    // the S in [0, M) with S * 2^K == A * B (mod M)
    function automatic int ref_mont(input int a, input int b, input int m);
        int ab = (a * b) % m;
        for (int s = 0; s < m; s++)
            if (((s << K) % m) == ab) return s;
        return -1;
    endfunction
    always @(negedge clk) begin
        if (rst_n && bus.o_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got a pulse expected none");
            end else begin
                e    = sb.pop_front();
                ms   = int'(bus.o_S);
                md   = int'(bus.o_D);
                msel = bus.o_Sel ? md : ms;
                chk("sel_result", msel, e.sel);
                chk("sel_flag", int'(bus.o_Sel), int'(ms >= e.m));
                chk("diff", md, (ms - e.m) & MASK);
                chk("raw_range", int'(ms == e.sel || ms == e.sel + e.m), 1);
                if (e.exact) begin
                    chk("raw_S", ms, e.s);
                    chk("raw_D", md, e.d);
                end
            end
            if (gap_en && last_done >= 0) chk("done_gap", cyc - last_done, K + 2);
            last_done = cyc;
        end
    end
    task automatic push_exp(input int a, input int b, input int m, input bit exact, input int es, input int ed);
        exp_t x;
        x = '{sel: ref_mont(a, b, m), m: m, exact: exact, s: es, d: ed};
        sb.push_back(x);
    endtask
    task automatic set_ops(input int a, input int b, input int m);
        bus.i_A = a[K-1:0];
        bus.i_B = b[K-1:0];
        bus.i_M = m[K-1:0];
    endtask
    task automatic run_op(input int a, input int b, input int m, input bit exact, input int es, input int ed);
        int n = 0;
        int nb = 0;
        @(negedge clk);
        set_ops(a, b, m);
        push_exp(a, b, m, exact, es, ed);
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        while (!bus.o_done && n < 30) begin
            nb += int'(bus.o_busy);
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, K);
        chk("busy_cycles", nb, K);
        @(posedge clk);
        #1 chk("done_pulse", int'(bus.o_done), 0);
    endtask
    initial begin
        int m, a, b;
        bus.i_start = 1'b0;
        set_ops(0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_S", int'(bus.o_S), 0);
        chk("rst_D", int'(bus.o_D), 0);
        chk("rst_Sel", int'(bus.o_Sel), 0);
        run_op(1, 1, 239, 1'b1, 225, 498);
        run_op(0, 200, 239, 1'b1, 0, 273);
        run_op(123, 200, 239, 1'b0, 0, 0);
        // abort at RUN iteration 4; outputs still hold the previous nonzero result until reset hits
        @(negedge clk);
        set_ops(238, 238, 239);
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_busy", int'(bus.o_busy), 0);
        chk("async_done", int'(bus.o_done), 0);
        chk("async_S", int'(bus.o_S), 0);
        chk("async_D", int'(bus.o_D), 0);
        chk("async_Sel", int'(bus.o_Sel), 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        run_op(238, 238, 239, 1'b0, 0, 0);
        // start held high: operands scrambled during RUN/DONE must not leak into the result
        gap_en = 1'b1;
        last_done = -1;
        @(negedge clk);
        a = 17; b = 99; m = 101;
        set_ops(a, b, m);
        push_exp(a, b, m, 1'b0, 0, 0);
        bus.i_start = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            repeat (K + 1) begin
                @(negedge clk);
                set_ops($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            end
            @(negedge clk);
            if (j < 3) begin
                m = $urandom_range(1, 127) * 2 + 1;
                a = $urandom_range(0, m - 1);
                b = $urandom_range(0, m - 1);
                set_ops(a, b, m);
                push_exp(a, b, m, 1'b0, 0, 0);
            end else bus.i_start = 1'b0;
        end
        repeat (K + 4) @(posedge clk);
        gap_en = 1'b0;
        chk("gap_queue_empty", sb.size(), 0);
        for (int i = 0; i < 500; i++) begin
            m = $urandom_range(1, 127) * 2 + 1;
            a = $urandom_range(0, m - 1);
            b = $urandom_range(0, m - 1);
            run_op(a, b, m, 1'b0, 0, 0);
        end
        repeat (4) @(posedge clk);
        chk("final_queue_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
